// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl
// Description : Load/store unit sitting after the ALU. Issues one data-memory
//               transaction per request over a valid/ready bus, extracts and
//               sign/zero-extends load lanes, builds store byte enables and
//               lane-replicated write data, and reports misaligned, illegal
//               and bus-timeout errors.
// Ports       : clk, reset (async, active-high)
//               start/is_load/is_store/funct3/addr/wdata : request from core
//               mem_req/mem_we/mem_addr/mem_wdata/mem_be  : bus request
//               mem_ready/mem_rdata                       : bus response
//               busy/done/rdata/err/err_code              : status to core
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_ctrl #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            is_load,
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] rdata,
    output logic            err,
    output logic [1:0]      err_code
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [1:0] c_ERR_MISALIGN = 2'b01;
    localparam logic [1:0] c_ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0] c_ERR_TIMEOUT  = 2'b11;

    state_t          r_state;
    logic [2:0]      r_f3;
    logic [1:0]      r_off;
    logic [TW-1:0]   r_cnt;

    // ------------------------------------------------------------------
    // Request decode (only meaningful in IDLE)
    // ------------------------------------------------------------------
    logic            w_legal_load;
    logic            w_legal_store;
    logic            w_illegal;
    logic            w_misalign;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata;

    always_comb begin
        w_legal_load  = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                        (funct3 == 3'b010) || (funct3 == 3'b100) ||
                        (funct3 == 3'b101);
        w_legal_store = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                        (funct3 == 3'b010);
        w_illegal     = (is_load && is_store) ||
                        (is_load && !w_legal_load) ||
                        (is_store && !w_legal_store);
        // funct3[1:0] encodes the access size for every legal opcode;
        // illegal encodings are filtered first, so any value seen here is fine.
        w_misalign    = ((funct3[1:0] == 2'b01) && addr[0]) ||
                        ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

        w_be    = 4'b1111;
        w_wdata = wdata;
        if (is_store) begin
            case (funct3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << addr[1:0];
                    w_wdata = {4{wdata[7:0]}};
                end
                2'b01: begin
                    w_be    = addr[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{wdata[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = wdata;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Load lane extraction from the latched offset and funct3
    // ------------------------------------------------------------------
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load_val;

    always_comb begin
        case (r_off)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (r_f3)
            3'b000:  w_load_val = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b001:  w_load_val = {{(XLEN-16){w_half[15]}}, w_half};
            3'b100:  w_load_val = {{(XLEN-8){1'b0}}, w_byte};
            3'b101:  w_load_val = {{(XLEN-16){1'b0}}, w_half};
            default: w_load_val = mem_rdata;
        endcase
    end

    logic [TW-1:0] w_cnt_next;
    assign w_cnt_next = r_cnt + TW'(1);

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_f3      <= 3'b000;
            r_off     <= 2'b00;
            r_cnt     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= 4'b0000;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'b00;
            rdata     <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && (is_load || is_store)) begin
                        busy <= 1'b1;
                        if (w_illegal) begin
                            r_state  <= S_ERR;
                            err      <= 1'b1;
                            err_code <= c_ERR_ILLEGAL;
                        end else if (w_misalign) begin
                            r_state  <= S_ERR;
                            err      <= 1'b1;
                            err_code <= c_ERR_MISALIGN;
                        end else begin
                            r_state   <= S_REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {addr[XLEN-1:2], 2'b00};
                            mem_be    <= w_be;
                            mem_wdata <= w_wdata;
                            r_f3      <= funct3;
                            r_off     <= addr[1:0];
                            r_cnt     <= '0;
                        end
                    end
                end
                S_REQ: begin
                    // Completion is checked first so a ready arriving on the
                    // final allowed cycle still finishes the transaction.
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        r_state <= S_DONE;
                        done    <= 1'b1;
                        if (!mem_we) begin
                            rdata <= w_load_val;
                        end
                    end else begin
                        r_cnt <= w_cnt_next;
                        if (w_cnt_next == TW'(TIMEOUT)) begin
                            mem_req  <= 1'b0;
                            r_state  <= S_ERR;
                            err      <= 1'b1;
                            err_code <= c_ERR_TIMEOUT;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                S_ERR: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit directly downstream of the ALU. Takes the effective address (ALU sum of rs1 and the immediate), store data (rs2) and funct3.
- Runs one data-memory transaction over a valid/ready bus:
  - loads: extracts the addressed byte or halfword and sign- or zero-extends it;
  - stores: generates byte enables and replicated write data.
- Flags misaligned accesses, illegal funct3 and bus timeout, so the core can stall on busy.

Parameters:
- XLEN, 32, datapath/address width (only 32 supported).
- TIMEOUT, 255, max cycles in REQ without mem_ready before a timeout error; legal range 1..255.
- TW, 8, width of timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request strobe, sampled only in IDLE.
- is_load  in  1  request is a load.
- is_store  in  1  request is a store.
- funct3  in  3  RV32I width/sign field.
- addr  in  XLEN  effective byte address from ALU.
- wdata  in  XLEN  store data (rs2).
- mem_req  out  1  bus request valid.
- mem_we  out  1  1=write, 0=read.
- mem_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00}).
- mem_wdata  out  XLEN  lane-replicated write data.
- mem_be  out  4  byte enables.
- mem_ready  in  1  bus accepts/completes in this cycle.
- mem_rdata  in  XLEN  read word, valid when mem_req&&mem_ready.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.
- rdata  out  XLEN  extended load result.
- err  out  1  one-cycle error pulse.
- err_code  out  2  01 misaligned, 10 illegal, 11 timeout; holds until next err.

Behaviour:
- Reset (async, any state): state=IDLE. mem_req, mem_we, done, err, busy = 0; mem_addr, mem_wdata, rdata = 0; mem_be=0000; err_code=00; timeout counter=0.
- All outputs are registered. Any in-flight transaction is abandoned; no done or err is produced for it.
- States: IDLE, REQ, DONE, ERR.
- IDLE, start=1 with exactly one of is_load/is_store:
  - Legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal store funct3: 000 SB, 001 SH, 010 SW. Anything else is illegal, and so is is_load&&is_store.
  - Misaligned: halfword access with addr[0]=1, or word access with addr[1:0]!=00.
  - Illegal takes priority over misaligned. Either error -> ERR with err_code set; no mem_req is issued.
  - Otherwise -> REQ. Latch mem_addr, mem_we, mem_be, mem_wdata, plus funct3 and addr[1:0] internally; mem_req=1 next cycle; counter cleared.
- IDLE, start=1 with neither is_load nor is_store: ignored. start outside IDLE: ignored.
- Store lanes:
  - SB: be=0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - SH: be=0011<<(2*addr[1]), wdata={2{wdata[15:0]}}.
  - SW: be=1111, wdata unchanged.
  - Loads drive be=1111.
- REQ:
  - Address, we, be and wdata stay stable while mem_req=1.
  - mem_req&&mem_ready at the edge:
    - mem_req drops next cycle; -> DONE.
    - For loads, rdata captures the extracted lane: byte=mem_rdata>>(8*addr[1:0]), half=mem_rdata>>(16*addr[1]). Sign-extend LB/LH, zero-extend LBU/LHU.
  - No ready: counter increments. The cycle the counter reaches TIMEOUT -> ERR with code 11; mem_req drops next cycle.
  - mem_ready arriving in the same cycle the counter would reach TIMEOUT: completion wins.
- DONE: done=1 for exactly one cycle -> IDLE. busy is low the cycle after done.
- ERR: err=1 for exactly one cycle -> IDLE.
- rdata holds its value until the next successful load; stores and errors leave it unchanged.
- Latency: start->mem_req is 1 cycle. Zero-wait bus gives start->done = 2 cycles (done in cycle N+2). Each wait cycle adds 1.
- mem_ready outside REQ is ignored.

Test Plan:
- Zero-wait LW: addr=0x100, mem_rdata=0xDEADBEEF, mem_ready=1 -> mem_req cycle N+1, done cycle N+2, rdata=0xDEADBEEF, busy low at N+3.
- LB/LBU on 0x103 with mem_rdata=0x80112233 -> LB rdata=0xFFFFFF80; LBU rdata=0x00000080. LH on 0x102 -> 0xFFFF8011.
- SB addr=0x201 wdata=0x000000A5 -> mem_be=0010, mem_wdata=0xA5A5A5A5, mem_addr=0x200, mem_we=1. SH addr=0x202 -> be=1100.
- Errors:
  - LW addr=0x102 -> err pulse, err_code=01, mem_req never asserted.
  - funct3=011 load -> err_code=10.
  - is_load=is_store=1 -> err_code=10.
- Timeout with TIMEOUT=4, mem_ready held 0 -> mem_req high 4 cycles, err with code 11, then IDLE. Ready on the 4th cycle -> done instead.
- Reset asserted mid-REQ with 3 wait cycles -> outputs zero immediately (async). No done or err after release. A new LW then completes normally.
